gray_seq_ctrl: RTL and testbench

//  Sequencer for the 4-bit Gray counter (gray_4bits) on the board LED path.
//  - Generates the counter's clk_en as single-cycle tick pulses at a fixed

---
 rtl/gray_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_gray_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_ctrl.sv
// Tick sequencer for gray_4bits: divided clk_en ticks, run/pause/step, and lap detection.
// Optional auto-stop after laps_max laps is enabled by defining GRAY_SEQ_CTRL_AUTOSTOP_EN.
module gray_seq_ctrl #(
    parameter int DIV   = 10,
    parameter int LAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [3:0]       gray_in,
`ifdef GRAY_SEQ_CTRL_AUTOSTOP_EN
    input  logic [LAP_W-1:0] laps_max,
`endif
    output logic             clk_en,
    output logic             busy,
    output logic [1:0]       state,
    output logic [LAP_W-1:0] lap_cnt,
    output logic             wrap
);

    localparam int PW = $clog2(DIV) + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [3:0]       gray_prev;
    logic             clk_en_d;
    logic             wrap_d;
    logic             lap_hit;
    logic             autostop;
    logic [LAP_W-1:0] lap_d;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        clk_en_d = 1'b0;
        lap_hit  = (gray_prev == 4'b1000) && (gray_in == 4'b0000);
        wrap_d   = lap_hit;
        lap_d    = (lap_hit && (lap_cnt != '1)) ? lap_cnt + 1'b1 : lap_cnt;
`ifdef GRAY_SEQ_CTRL_AUTOSTOP_EN
        autostop = lap_hit && (laps_max != '0) && (lap_d == laps_max);
`else
        autostop = 1'b0;
`endif

        // The tick is registered, so it appears the cycle after the prescaler wraps.
        unique case (state_q)
            IDLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                    presc_d = '0;
                end else if (step) begin
                    state_d  = STEP;
                    clk_en_d = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (autostop) begin
                    state_d = DONE;
                end else if (start) begin
                    presc_d = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d  = '0;
                    clk_en_d = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            STEP: begin
                state_d = IDLE;
            end
            DONE: begin
`ifdef GRAY_SEQ_CTRL_AUTOSTOP_EN
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                    presc_d = '0;
                    lap_d   = '0;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            clk_en    <= 1'b0;
            wrap      <= 1'b0;
            lap_cnt   <= '0;
            gray_prev <= '0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            clk_en    <= clk_en_d;
            wrap      <= wrap_d;
            lap_cnt   <= lap_d;
            gray_prev <= gray_in;
        end
    end

    assign state = state_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl: emulates gray_4bits and compares against a behavioural model.
module tb_gray_seq_ctrl;

    localparam int DIV     = 10;
    localparam int LAP_W   = 4;
    localparam int LAP_MAX = (1 << LAP_W) - 1;

    logic             clk = 1'b0;
    logic             rst, start, stop, step;
    logic [3:0]       gray_in;
    logic             clk_en, busy, wrap;
    logic [1:0]       state;
    logic [LAP_W-1:0] lap_cnt;
`ifdef GRAY_SEQ_CTRL_AUTOSTOP_EN
    logic [LAP_W-1:0] laps_max;
`endif

    gray_seq_ctrl #(.DIV(DIV), .LAP_W(LAP_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .step    (step),
        .gray_in (gray_in),
`ifdef GRAY_SEQ_CTRL_AUTOSTOP_EN
        .laps_max(laps_max),
`endif
        .clk_en  (clk_en),
        .busy    (busy),
        .state   (state),
        .lap_cnt (lap_cnt),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int bin   = 0;
    int tick_total = 0;
    int gmode = 0;
    bit alt   = 1'b0;

    // Model state: mode 0=IDLE 1=RUN 2=STEP 3=DONE; age counts cycles since the run phase began.
    int m_mode = 0, m_age = 0, m_lap = 0, m_prev = 0;
    bit m_clk = 0, m_wrap = 0, chk_on = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit s_start, input bit s_stop, input bit s_step);
        start = s_start;
        stop  = s_stop;
        step  = s_step;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        step  = 1'b0;
    endtask

    // Stand-in for gray_4bits: advances on each observed tick, or plays synthetic patterns.
    always @(negedge clk) begin
        logic [3:0] b4;
        if (clk_en === 1'b1) begin
            bin++;
            tick_total++;
        end
        b4 = bin[3:0];
        case (gmode)
            0: gray_in = b4 ^ (b4 >> 1);
            1: begin
                alt = ~alt;
                gray_in = alt ? 4'b1000 : 4'b0000;
            end
            default: begin
                case ($urandom_range(0, 3))
                    0:       gray_in = 4'b0000;
                    1, 2:    gray_in = 4'b1000;
                    default: gray_in = 4'b1100;
                endcase
            end
        endcase
    end

    always @(posedge clk) begin
        bit det, hit;
        int lap_n;
        if (rst !== 1'b1) begin
            m_mode = 0; m_age = 0; m_clk = 0; m_lap = 0; m_wrap = 0; m_prev = 0;
            chk_on = 1'b1;
        end else begin
            det    = (m_prev == 8) && (gray_in == 4'd0);
            m_prev = int'(gray_in);
            m_wrap = det;
            lap_n  = (det && m_lap < LAP_MAX) ? m_lap + 1 : m_lap;
            hit    = 1'b0;
`ifdef GRAY_SEQ_CTRL_AUTOSTOP_EN
            hit    = det && (laps_max != 0) && (lap_n == int'(laps_max));
`endif
            m_clk  = 1'b0;
            case (m_mode)
                0: begin
                    if (stop) m_mode = 0;
                    else if (start) begin m_mode = 1; m_age = 0; end
                    else if (step) begin m_mode = 2; m_clk = 1'b1; end
                end
                1: begin
                    if (stop) m_mode = 0;
                    else if (hit) m_mode = 3;
                    else if (start) m_age = 0;
                    else begin
                        m_age++;
                        m_clk = (m_age % DIV) == 0;
                    end
                end
                2: m_mode = 0;
                default: begin
                    if (stop) m_mode = 0;
                    else if (start) begin m_mode = 1; m_age = 0; lap_n = 0; end
                end
            endcase
            m_lap = lap_n;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checkOutput("state",   state,   m_mode);
            checkOutput("clk_en",  clk_en,  m_clk);
            checkOutput("busy",    busy,    m_mode != 0);
            checkOutput("lap_cnt", lap_cnt, m_lap);
            checkOutput("wrap",    wrap,    m_wrap);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; gray_in = 4'd0;
`ifdef GRAY_SEQ_CTRL_AUTOSTOP_EN
        laps_max = '0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b1;
        checkOutput("rst_state", state, 0);
        checkOutput("rst_clk_en", clk_en, 0);
        checkOutput("rst_lap", lap_cnt, 0);

        // Free run: tick spacing and the first full lap.
        tick_total = 0;
        applyStimulus(1, 0, 0);
        n = 0;
        while (clk_en !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checkOutput("first_tick_delay", n, DIV);
        @(negedge clk);
        checkOutput("tick_width", clk_en, 0);
        n = 1;
        while (clk_en !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checkOutput("tick_gap", n, DIV);
        n = 0;
        while (lap_cnt !== 4'd1 && n < 300) begin @(negedge clk); n++; end
        checkOutput("lap_after_16", lap_cnt, 1);
        checkOutput("ticks_per_lap", tick_total, 16);
        checkOutput("wrap_pulse", wrap, 1);
        applyStimulus(0, 1, 0);
        checkOutput("stop_idle", state, 0);

        // Three single steps from IDLE.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1);
            checkOutput("step_state", state, 2);
            checkOutput("step_tick", clk_en, 1);
            repeat (3) @(negedge clk);
            checkOutput("step_back_idle", state, 0);
        end
        checkOutput("step_gray", gray_in, 4'b0010);
        checkOutput("step_busy", busy, 0);

        // Stop lands exactly when the prescaler is at its last count.
        applyStimulus(1, 0, 0);
        n = 0;
        while (clk_en !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        repeat (DIV - 1) @(negedge clk);
        applyStimulus(0, 1, 0);
        checkOutput("stop_wins_tick", clk_en, 0);
        checkOutput("stop_wins_state", state, 0);

        // Simultaneous commands in IDLE.
        applyStimulus(1, 1, 0);
        checkOutput("start_stop_idle", state, 0);
        applyStimulus(1, 0, 1);
        checkOutput("start_step_run", state, 1);
        checkOutput("start_step_notick", clk_en, 0);

        // Reset in the middle of a run.
        n = 0;
        while (lap_cnt !== 4'd3 && n < 1200) begin @(negedge clk); n++; end
        checkOutput("lap_reach3", lap_cnt, 3);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("midrun_rst_state", state, 0);
        checkOutput("midrun_rst_lap", lap_cnt, 0);
        checkOutput("midrun_rst_busy", busy, 0);
        n = tick_total;
        repeat (30) @(negedge clk);
        checkOutput("no_tick_after_rst", tick_total - n, 0);

`ifdef GRAY_SEQ_CTRL_AUTOSTOP_EN
        laps_max = 4'd2;
        applyStimulus(1, 0, 0);
        n = 0;
        while (state !== 2'b11 && n < 1200) begin @(negedge clk); n++; end
        checkOutput("autostop_done", state, 3);
        checkOutput("autostop_lap", lap_cnt, 2);
        n = tick_total;
        repeat (20) @(negedge clk);
        checkOutput("done_no_tick", tick_total - n, 0);
        checkOutput("done_busy", busy, 1);
        applyStimulus(1, 0, 0);
        checkOutput("done_restart_state", state, 1);
        checkOutput("done_restart_lap", lap_cnt, 0);
        n = 0;
        while (clk_en !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checkOutput("done_first_tick", n, DIV);
        laps_max = '0;
        applyStimulus(0, 1, 0);
`endif

        // Rapid synthetic laps drive the counter into saturation.
        gmode = 1;
        repeat (60) @(negedge clk);
        checkOutput("lap_saturate", lap_cnt, LAP_MAX);
        gmode = 0;

        // Randomised command traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 6000; i++) begin
            if (i % 250 == 0) begin
                gmode = ($urandom_range(0, 3) == 0) ? 2 : 0;
`ifdef GRAY_SEQ_CTRL_AUTOSTOP_EN
                laps_max = LAP_W'($urandom_range(0, 3));
`endif
            end
            rst   = ($urandom_range(0, 499) != 0);
            start = ($urandom_range(0, 99) < 2);
            stop  = ($urandom_range(0, 99) < 1);
            step  = ($urandom_range(0, 99) < 3);
            @(negedge clk);
        end
        rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
